// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - line layout, FSM states and helper functions for the cache miss controller
package cache_pkg;

  localparam int CACHE_ADDR_W  = 5;
  localparam int CACHE_INDEX_W = 3;
  localparam int CACHE_DATA_W  = 8;
  localparam int TAG_W         = CACHE_ADDR_W - CACHE_INDEX_W;
  localparam int LINE_W        = 3 + TAG_W + CACHE_DATA_W;

  localparam int VALID_B = LINE_W - 1;
  localparam int DIRTY_B = LINE_W - 2;
  localparam int LRU_B   = LINE_W - 3;
  localparam int TAG_HI  = LINE_W - 4;
  localparam int TAG_LO  = CACHE_DATA_W;
  localparam int DATA_HI = CACHE_DATA_W - 1;
  localparam int DATA_LO = 0;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, COMPARE, WB, FETCH, FILL, DONE
  } state_e;

  function automatic logic [LINE_W-1:0] make_line(
    input logic                    valid,
    input logic                    dirty,
    input logic                    lru,
    input logic [TAG_W-1:0]        tag,
    input logic [CACHE_DATA_W-1:0] data
  );
    return {valid, dirty, lru, tag, data};
  endfunction

  // lru lives in way0 only: 0 evicts way0, 1 evicts way1; invalid ways are always preferred
  function automatic logic victim_sel(
    input logic [LINE_W-1:0] e0,
    input logic [LINE_W-1:0] e1
  );
    if (!e0[VALID_B])      return 1'b0;
    else if (!e1[VALID_B]) return 1'b1;
    else                   return e0[LRU_B];
  endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// rtl/lru_victim_sel.sv - picks the eviction way of a set and reports whether it needs write-back
module lru_victim_sel
  import cache_pkg::*;
(
  input  logic [LINE_W-1:0] e0,
  input  logic [LINE_W-1:0] e1,
  output logic              victim,
  output logic              victim_dirty
);

  logic unused_bits;

  assign victim       = victim_sel(e0, e1);
  assign victim_dirty = victim ? (e1[VALID_B] & e1[DIRTY_B])
                               : (e0[VALID_B] & e0[DIRTY_B]);
  assign unused_bits  = ^{e0[TAG_HI:DATA_LO], e1[LRU_B], e1[TAG_HI:DATA_LO]};

endmodule

// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - 2-way set-associative cache controller: lookup, LRU eviction, write-back and fill
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = CACHE_ADDR_W,
  parameter int INDEX_W = CACHE_INDEX_W,
  parameter int DATA_W  = CACHE_DATA_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ready,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               hit,
  output logic               miss,
  output logic [INDEX_W-1:0] way_index,
  input  logic [LINE_W-1:0]  way0_rdata,
  input  logic [LINE_W-1:0]  way1_rdata,
  output logic               way0_we,
  output logic               way1_we,
  output logic [LINE_W-1:0]  way0_wdata,
  output logic [LINE_W-1:0]  way1_wdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_re,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_valid
);

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 we_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [LINE_W-1:0]    e0_q;
  logic                 vic_q;
  logic                 cpu_ready_q, hit_q, miss_q, way0_we_q, way1_we_q, mem_we_q, mem_re_q;
  logic [DATA_W-1:0]    cpu_rdata_q, mem_wdata_q;
  logic [INDEX_W-1:0]   way_index_q;
  logic [LINE_W-1:0]    way0_wdata_q, way1_wdata_q;
  logic [ADDR_W-1:0]    mem_addr_q;

  logic [TAG_W-1:0]     tag;
  logic                 hit0, hit1, victim, victim_dirty, f_vic;
  logic [LINE_W-1:0]    vic_line, f_e0, fill0, fill1, hit0_line, hit1_line, lru0_line;
  logic [DATA_W-1:0]    f_data;

  lru_victim_sel u_victim (
    .e0           (way0_rdata),
    .e1           (way1_rdata),
    .victim       (victim),
    .victim_dirty (victim_dirty)
  );

  assign tag      = addr_q[ADDR_W-1:INDEX_W];
  assign hit0     = way0_rdata[VALID_B] && (way0_rdata[TAG_HI:TAG_LO] == tag);
  assign hit1     = !hit0 && way1_rdata[VALID_B] && (way1_rdata[TAG_HI:TAG_LO] == tag);
  assign vic_line = victim ? way1_rdata : way0_rdata;

  // Fill lines are shared by the COMPARE (write miss), WB and FETCH exits.
  always_comb begin
    f_vic  = (state_q == COMPARE) ? victim : vic_q;
    f_e0   = (state_q == COMPARE) ? way0_rdata : e0_q;
    f_data = we_q ? wdata_q : mem_rdata;
    fill0  = make_line(1'b1, we_q, 1'b1, tag, f_data);
    fill1  = make_line(1'b1, we_q, 1'b0, tag, f_data);
    if (f_vic) begin
      fill0        = f_e0;
      fill0[LRU_B] = 1'b0;
    end
    hit0_line = make_line(1'b1, way0_rdata[DIRTY_B] | we_q, 1'b1, tag,
                          we_q ? wdata_q : way0_rdata[DATA_HI:DATA_LO]);
    hit1_line = make_line(1'b1, 1'b1, way1_rdata[LRU_B], tag, wdata_q);
    lru0_line        = way0_rdata;
    lru0_line[LRU_B] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      e0_q         <= '0;
      vic_q        <= 1'b0;
      cpu_ready_q  <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      cpu_rdata_q  <= '0;
      way_index_q  <= '0;
      way0_we_q    <= 1'b0;
      way1_we_q    <= 1'b0;
      way0_wdata_q <= '0;
      way1_wdata_q <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      mem_re_q     <= 1'b0;
    end else begin
      cpu_ready_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      way0_we_q   <= 1'b0;
      way1_we_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        IDLE: if (cpu_req) begin
          addr_q      <= cpu_addr;
          we_q        <= cpu_we;
          wdata_q     <= cpu_wdata;
          way_index_q <= cpu_addr[INDEX_W-1:0];
          state_q     <= LOOKUP;
        end
        LOOKUP: state_q <= COMPARE;
        COMPARE: begin
          e0_q  <= way0_rdata;
          vic_q <= victim;
          if (hit0 || hit1) begin
            state_q     <= DONE;
            cpu_ready_q <= 1'b1;
            hit_q       <= 1'b1;
            way0_we_q   <= 1'b1;
            if (hit0) begin
              way0_wdata_q <= hit0_line;
              if (!we_q) cpu_rdata_q <= way0_rdata[DATA_HI:DATA_LO];
            end else begin
              way0_wdata_q <= lru0_line;
              way1_we_q    <= we_q;
              way1_wdata_q <= hit1_line;
              if (!we_q) cpu_rdata_q <= way1_rdata[DATA_HI:DATA_LO];
            end
          end else if (victim_dirty) begin
            state_q     <= WB;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {vic_line[TAG_HI:TAG_LO], addr_q[INDEX_W-1:0]};
            mem_wdata_q <= vic_line[DATA_HI:DATA_LO];
          end else if (we_q) begin
            state_q      <= FILL;
            way0_we_q    <= 1'b1;
            way1_we_q    <= f_vic;
            way0_wdata_q <= fill0;
            way1_wdata_q <= fill1;
          end else begin
            state_q    <= FETCH;
            mem_re_q   <= 1'b1;
            mem_addr_q <= addr_q;
          end
        end
        WB: if (we_q) begin
          state_q      <= FILL;
          way0_we_q    <= 1'b1;
          way1_we_q    <= f_vic;
          way0_wdata_q <= fill0;
          way1_wdata_q <= fill1;
        end else begin
          state_q    <= FETCH;
          mem_re_q   <= 1'b1;
          mem_addr_q <= addr_q;
        end
        FETCH: if (mem_valid) begin
          state_q      <= FILL;
          mem_re_q     <= 1'b0;
          cpu_rdata_q  <= mem_rdata;
          way0_we_q    <= 1'b1;
          way1_we_q    <= f_vic;
          way0_wdata_q <= fill0;
          way1_wdata_q <= fill1;
        end
        FILL: begin
          state_q     <= DONE;
          cpu_ready_q <= 1'b1;
          miss_q      <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign way_index  = way_index_q;
  assign way0_we    = way0_we_q;
  assign way1_we    = way1_we_q;
  assign way0_wdata = way0_wdata_q;
  assign way1_wdata = way1_wdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_re     = mem_re_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - self-checking bench for cache_miss_ctrl with way-array and memory models
module tb_cache_miss_ctrl;
  import cache_pkg::*;

  logic              clock, reset;
  logic              cpu_req, cpu_we, cpu_ready, hit, miss;
  logic [4:0]        cpu_addr, mem_addr;
  logic [7:0]        cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [2:0]        way_index;
  logic [12:0]       way0_rdata, way1_rdata, way0_wdata, way1_wdata;
  logic              way0_we, way1_we, mem_we, mem_re, mem_valid;

  cache_miss_ctrl dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .hit(hit), .miss(miss), .way_index(way_index),
    .way0_rdata(way0_rdata), .way1_rdata(way1_rdata), .way0_we(way0_we),
    .way1_we(way1_we), .way0_wdata(way0_wdata), .way1_wdata(way1_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  // Passive storage: way arrays with one-cycle synchronous read, plus main memory
  logic [12:0] w0_mem [8];
  logic [12:0] w1_mem [8];
  logic [7:0]  mem    [32];
  logic        ram_clr;

  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 8; i++) begin
        w0_mem[i] <= '0;
        w1_mem[i] <= '0;
      end
      for (int i = 0; i < 32; i++) mem[i] <= 8'h40 + 8'(i);
      mem[11] <= 8'hA5;
    end else begin
      way0_rdata <= w0_mem[way_index];
      way1_rdata <= w1_mem[way_index];
      if (way0_we) w0_mem[way_index] <= way0_wdata;
      if (way1_we) w1_mem[way_index] <= way1_wdata;
      if (mem_we)  mem[mem_addr] <= mem_wdata;
    end
  end

  // Memory responder: mem_valid two cycles after mem_re is first seen, unless disabled
  logic mem_auto, force_valid;
  int   mcnt = 0;
  always @(negedge clock) begin
    logic av;
    av = 1'b0;
    if (mem_re && mem_auto) begin
      if (mcnt == 2) begin
        av   = 1'b1;
        mcnt = 0;
      end else mcnt = mcnt + 1;
    end else mcnt = 0;
    mem_valid = av | force_valid;
    mem_rdata = mem[mem_addr];
  end

  // Event monitor: counters only, read by the checking process
  int         nwb = 0, nre = 0, nwway = 0, nready = 0, wb_cyc = 0, re_cyc = 0;
  logic [4:0] wb_a;
  logic [7:0] wb_d;
  logic       prev_re = 1'b0;
  always @(negedge clock) begin
    if (mem_we) begin
      nwb    = nwb + 1;
      wb_a   = mem_addr;
      wb_d   = mem_wdata;
      wb_cyc = cyc;
    end
    if (mem_re && !prev_re) begin
      nre    = nre + 1;
      re_cyc = cyc;
    end
    prev_re = mem_re;
    if (way0_we || way1_we) nwway = nwway + 1;
    if (cpu_ready) nready = nready + 1;
  end

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [7:0]  wdata;
    logic        hit;
    logic [7:0]  rdata;
    int          lat;
    int          nwb;
    logic [4:0]  wb_addr;
    logic [7:0]  wb_data;
    int          nre;
    logic [12:0] w0;
    logic [12:0] w1;
  } vec_t;

  typedef struct {
    vec_t v;
    int   t0;
    int   wb0;
    int   re0;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[12];
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [12:0] ln(input int v, input int d, input int l, input int t,
                                     input logic [7:0] dt);
    logic [1:0] tg;
    tg = t[1:0];
    return {v[0], d[0], l[0], tg, dt};
  endfunction

  task automatic do_req(input vec_t v);
    exp_t e;
    bit   got;
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    e.v   = v;
    e.t0  = cyc;
    e.wb0 = nwb;
    e.re0 = nre;
    sbq.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock); #1;
      if (cpu_ready) got = 1'b1;
    end
    cpu_req = 1'b0;
    e = sbq.pop_front();
    if (!got) begin
      chk("ready_timeout", 0, 1);
    end else begin
      chk("hit", int'(hit), int'(e.v.hit));
      chk("miss", int'(miss), int'(!e.v.hit));
      if (!e.v.we) chk("rdata", int'(cpu_rdata), int'(e.v.rdata));
      chk("latency", cyc - e.t0, e.v.lat);
      chk("wb_count", nwb - e.wb0, e.v.nwb);
      if (e.v.nwb != 0) begin
        chk("wb_addr", int'(wb_a), int'(e.v.wb_addr));
        chk("wb_data", int'(wb_d), int'(e.v.wb_data));
      end
      chk("fetch_count", nre - e.re0, e.v.nre);
      if (e.v.nwb != 0 && e.v.nre != 0) chk("wb_before_fetch", int'(wb_cyc < re_cyc), 1);
    end
    @(negedge clock); #1;
    chk("way0_entry", int'(w0_mem[e.v.addr[2:0]]), int'(e.v.w0));
    chk("way1_entry", int'(w1_mem[e.v.addr[2:0]]), int'(e.v.w1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    int   ww0, rd0;
    bit   seen;

    ram_clr = 1'b1; reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; force_valid = 1'b0; mem_auto = 1'b1;

    //       we    addr      wdata  hit   rdata  lat wb  wb_addr   wb_data re  way0                    way1
    vt[0]  = '{1'b0, 5'b01011, 8'h00, 1'b0, 8'hA5, 7, 0, 5'b00000, 8'h00, 1, ln(1,0,1,1,8'hA5), 13'h0};
    vt[1]  = '{1'b0, 5'b01011, 8'h00, 1'b1, 8'hA5, 3, 0, 5'b00000, 8'h00, 0, ln(1,0,1,1,8'hA5), 13'h0};
    vt[2]  = '{1'b1, 5'b01011, 8'h3C, 1'b1, 8'h00, 3, 0, 5'b00000, 8'h00, 0, ln(1,1,1,1,8'h3C), 13'h0};
    vt[3]  = '{1'b0, 5'b10011, 8'h00, 1'b0, 8'h53, 7, 0, 5'b00000, 8'h00, 1, ln(1,1,0,1,8'h3C), ln(1,0,0,2,8'h53)};
    vt[4]  = '{1'b0, 5'b11011, 8'h00, 1'b0, 8'h5B, 8, 1, 5'b01011, 8'h3C, 1, ln(1,0,1,3,8'h5B), ln(1,0,0,2,8'h53)};
    vt[5]  = '{1'b1, 5'b00110, 8'h77, 1'b0, 8'h00, 4, 0, 5'b00000, 8'h00, 0, ln(1,1,1,0,8'h77), 13'h0};
    vt[6]  = '{1'b0, 5'b00110, 8'h00, 1'b1, 8'h77, 3, 0, 5'b00000, 8'h00, 0, ln(1,1,1,0,8'h77), 13'h0};
    vt[7]  = '{1'b1, 5'b01110, 8'h88, 1'b0, 8'h00, 4, 0, 5'b00000, 8'h00, 0, ln(1,1,0,0,8'h77), ln(1,1,0,1,8'h88)};
    vt[8]  = '{1'b1, 5'b10110, 8'h99, 1'b0, 8'h00, 5, 1, 5'b00110, 8'h77, 0, ln(1,1,1,2,8'h99), ln(1,1,0,1,8'h88)};
    vt[9]  = '{1'b0, 5'b01110, 8'h00, 1'b1, 8'h88, 3, 0, 5'b00000, 8'h00, 0, ln(1,1,0,2,8'h99), ln(1,1,0,1,8'h88)};
    vt[10] = '{1'b0, 5'b10011, 8'h00, 1'b1, 8'h53, 3, 0, 5'b00000, 8'h00, 0, ln(1,0,0,3,8'h5B), ln(1,0,0,2,8'h53)};
    vt[11] = '{1'b0, 5'b00011, 8'h00, 1'b0, 8'h43, 7, 0, 5'b00000, 8'h00, 1, ln(1,0,1,0,8'h43), ln(1,0,0,2,8'h53)};

    repeat (3) @(negedge clock);
    #1;
    ram_clr = 1'b0;
    chk("rst_cpu_ready", int'(cpu_ready), 0);
    chk("rst_cpu_rdata", int'(cpu_rdata), 0);
    chk("rst_hit_miss", int'({hit, miss}), 0);
    chk("rst_way_we", int'({way0_we, way1_we}), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_re", int'(mem_re), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_way_index", int'(way_index), 0);
    @(negedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #1;

    for (int i = 0; i < 12; i++) do_req(vt[i]);

    chk("mem_after_wb_set3", int'(mem[11]), 8'h3C);
    chk("mem_after_wb_set6", int'(mem[6]), 8'h77);

    // Reset while waiting in FETCH; the late mem_valid must be ignored
    mem_auto = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 5'b00101;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock); #1;
      if (mem_re) seen = 1'b1;
    end
    chk("abort_fetch_started", int'(seen), 1);
    ww0 = nwway;
    rd0 = nready;
    @(negedge clock); #1;
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(negedge clock); #1;
    chk("abort_mem_re_low", int'(mem_re), 0);
    chk("abort_ready_low", int'(cpu_ready), 0);
    reset = 1'b0;
    @(posedge clock); #2;
    force_valid = 1'b1;
    @(posedge clock); #2;
    force_valid = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    chk("abort_no_way_write", nwway - ww0, 0);
    chk("abort_no_ready", nready - rd0, 0);
    chk("abort_way0_set5", int'(w0_mem[5]), 0);
    chk("abort_mem_re_idle", int'(mem_re), 0);
    mem_auto = 1'b1;

    rv = '{1'b0, 5'b00101, 8'h00, 1'b0, 8'h45, 7, 0, 5'b00000, 8'h00, 1, ln(1,0,1,0,8'h45), 13'h0};
    do_req(rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
